word_index_decoder: RTL and testbench

- Inverse of the datapath's shift-left-2 offset stage: converts 32-bit byte addresses into word indices (address >> 2) for the instruction/data memory word ports of the pipeline CPU.
- Registered, valid/ready-handshaked stage with a 2-entry buffer, so the memory side can stall without dropping addresses.
- Flags misaligned addresses and reports the dropped byte offset.
- Sits between the address-generation logic (PC / ALU result) and the word-addressed memory.

---
 rtl/word_index_pkg.sv | 20 ++
 rtl/word_index_fifo2.sv | 62 ++++++
 rtl/word_index_decoder.sv | 75 +++++++
 tb/tb_word_index_decoder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/word_index_pkg.sv
// Shared constants for byte-address to word-index conversion.
// WORD_SHIFT is also used by the CPU's shift-left-2 offset stage.
package word_index_pkg;

    localparam int unsigned WORD_SHIFT = 2;
    localparam int unsigned OFFSET_W   = 2;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_IDX_W  = DEF_ADDR_W - WORD_SHIFT;

    typedef struct packed {
        logic [DEF_IDX_W-1:0] index;
        logic [OFFSET_W-1:0]  offset;
    } word_entry_t;

    function automatic int unsigned entry_w(input int unsigned addr_w);
        return addr_w - WORD_SHIFT + OFFSET_W;
    endfunction

endpackage

// File: rtl/word_index_fifo2.sv
// Generic 2-entry valid/ready buffer with registered outputs and synchronous flush.
module word_index_fifo2
    import word_index_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam logic [1:0] CountFull = 2'(FIFO_DEPTH);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [1:0]       count_q, count_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             push, pop;

    assign in_ready  = (count_q != CountFull);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            if (push && !pop)      count_d = count_q + 2'd1;
            else if (pop && !push) count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push && !flush) mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: rtl/word_index_decoder.sv
// Byte address -> word index stage (addr >> 2) with misalignment flag and 2-entry buffer.
// Optional saturating misalignment counter enabled by WORD_INDEX_MISALIGN_CNT_EN.
module word_index_decoder
    import word_index_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned IDX_W  = ADDR_W - WORD_SHIFT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic [1:0]        out_offset,
`ifdef WORD_INDEX_MISALIGN_CNT_EN
    output logic [15:0]       misalign_count,
`endif
    output logic              out_misaligned
);

    localparam int unsigned EntryW = entry_w(ADDR_W);

    typedef struct packed {
        logic [IDX_W-1:0]    index;
        logic [OFFSET_W-1:0] offset;
    } entry_t;

    entry_t in_entry, out_entry;

    // Pure truncating shift: the top bits are zero-filled, never sign-extended.
    assign in_entry.index  = in_addr[ADDR_W-1:WORD_SHIFT];
    assign in_entry.offset = in_addr[OFFSET_W-1:0];

    word_index_fifo2 #(
        .WIDTH (EntryW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_entry)
    );

    assign out_index      = out_entry.index;
    assign out_offset     = out_entry.offset;
    assign out_misaligned = |out_entry.offset;

`ifdef WORD_INDEX_MISALIGN_CNT_EN
    logic [15:0] mis_cnt_q, mis_cnt_d;

    // Counts downstream accepts even in a flush cycle; only reset clears it.
    always_comb begin
        mis_cnt_d = mis_cnt_q;
        if (out_valid && out_ready && out_misaligned && (mis_cnt_q != 16'hFFFF)) begin
            mis_cnt_d = mis_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mis_cnt_q <= 16'd0;
        else        mis_cnt_q <= mis_cnt_d;
    end

    assign misalign_count = mis_cnt_q;
`endif

endmodule

// File: tb/tb_word_index_decoder.sv
// Directed self-checking bench for word_index_decoder.
module tb_word_index_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] out_index;
    logic [1:0]  out_offset;
    logic        out_misaligned;
`ifdef WORD_INDEX_MISALIGN_CNT_EN
    logic [15:0] misalign_count;
`endif

    int checks   = 0;
    int failures = 0;

    word_index_decoder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_addr        (in_addr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_index      (out_index),
        .out_offset     (out_offset),
`ifdef WORD_INDEX_MISALIGN_CNT_EN
        .misalign_count (misalign_count),
`endif
        .out_misaligned (out_misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs changed after this settle before the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_addr   = 32'h0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_index", 32'(out_index), 32'h0);
        check("rst_offset", 32'(out_offset), 32'h0);
        rst_n = 1'b1;
        step();

        // Single aligned address, visible one cycle later
        in_valid = 1'b1;
        in_addr  = 32'h0000_1008;
        check("al_in_ready", 32'(in_ready), 32'h1);
        check("al_pre_valid", 32'(out_valid), 32'h0);
        step();
        in_valid = 1'b0;
        check("al_valid", 32'(out_valid), 32'h1);
        check("al_index", 32'(out_index), 32'h0000_0402);
        check("al_offset", 32'(out_offset), 32'h0);
        check("al_mis", 32'(out_misaligned), 32'h0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("al_drained", 32'(out_valid), 32'h0);

        // All-ones address: truncating shift, offset 3
        in_valid = 1'b1;
        in_addr  = 32'hFFFF_FFFF;
        step();
        in_valid = 1'b0;
        check("ff_index", 32'(out_index), 32'h3FFF_FFFF);
        check("ff_offset", 32'(out_offset), 32'h3);
        check("ff_mis", 32'(out_misaligned), 32'h1);
`ifdef WORD_INDEX_MISALIGN_CNT_EN
        check("ff_cnt0", 32'(misalign_count), 32'h0);
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("ff_drained", 32'(out_valid), 32'h0);
`ifdef WORD_INDEX_MISALIGN_CNT_EN
        check("ff_cnt1", 32'(misalign_count), 32'h1);
`endif

        // Backpressure: third address held while full
        in_valid = 1'b1;
        in_addr  = 32'h10;
        step();
        in_addr = 32'h20;
        check("bp_ready1", 32'(in_ready), 32'h1);
        step();
        in_addr = 32'h30;
        check("bp_full", 32'(in_ready), 32'h0);
        check("bp_valid", 32'(out_valid), 32'h1);
        step();
        check("bp_still_full", 32'(in_ready), 32'h0);
        check("bp_head0", 32'(out_index), 32'h4);
        out_ready = 1'b1;
        step();
        check("bp_head1", 32'(out_index), 32'h8);
        check("bp_ready_back", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        check("bp_head2", 32'(out_index), 32'hC);
        check("bp_valid2", 32'(out_valid), 32'h1);
        step();
        out_ready = 1'b0;
        check("bp_empty", 32'(out_valid), 32'h0);

        // Simultaneous push/pop with count held at 1
        in_valid = 1'b1;
        in_addr  = 32'h0;
        step();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_addr = 32'(i * 4);
            check("sim_index", 32'(out_index), 32'(i - 1));
            check("sim_valid", 32'(out_valid), 32'h1);
            check("sim_ready", 32'(in_ready), 32'h1);
            step();
        end
        in_valid = 1'b0;
        check("sim_last", 32'(out_index), 32'h8);
        step();
        out_ready = 1'b0;
        check("sim_empty", 32'(out_valid), 32'h0);

        // Flush while full discards buffered entries and the concurrent input
        in_valid = 1'b1;
        in_addr  = 32'h100;
        step();
        in_addr = 32'h104;
        step();
        check("fl_full", 32'(in_ready), 32'h0);
        flush   = 1'b1;
        in_addr = 32'h200;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", 32'(out_valid), 32'h0);
        check("fl_ready", 32'(in_ready), 32'h1);
        step();
        check("fl_discard", 32'(out_valid), 32'h0);
        in_valid = 1'b1;
        in_addr  = 32'h300;
        step();
        in_valid = 1'b0;
        check("fl_after_index", 32'(out_index), 32'hC0);
        check("fl_after_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Asynchronous reset while full of misaligned entries
        in_valid = 1'b1;
        in_addr  = 32'h41;
        step();
        in_addr = 32'h45;
        step();
        in_valid = 1'b0;
        check("ar_pre_full", 32'(in_ready), 32'h0);
        check("ar_pre_offset", 32'(out_offset), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 32'h0);
        check("ar_ready", 32'(in_ready), 32'h1);
        check("ar_index", 32'(out_index), 32'h0);
        check("ar_offset", 32'(out_offset), 32'h0);
        check("ar_mis", 32'(out_misaligned), 32'h0);
`ifdef WORD_INDEX_MISALIGN_CNT_EN
        check("ar_cnt", 32'(misalign_count), 32'h0);
`endif
        step();
        rst_n = 1'b1;
        step();
        check("ar_post_valid", 32'(out_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
